// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - mdOp encodings for the six operations the unit accepts
//   - FSM state type
//   - MDU_LAT: cycles busy stays high for an iterating op at the default
//     width; mdu_lat() gives the same figure for other widths.
package mdu_pkg;

  localparam logic [2:0] MD_MULT  = 3'b000;
  localparam logic [2:0] MD_MULTU = 3'b001;
  localparam logic [2:0] MD_DIV   = 3'b010;
  localparam logic [2:0] MD_DIVU  = 3'b011;
  localparam logic [2:0] MD_MTHI  = 3'b100;
  localparam logic [2:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    FIX  = 2'd2
  } state_t;

  localparam int MDU_WIDTH = 32;
  localparam int MDU_LAT   = MDU_WIDTH + 1;

  function automatic int mdu_lat(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step (combinational).
//   rem      : current partial remainder
//   din_bit  : next dividend bit shifted in
//   divisor  : divisor magnitude
//   rem_nxt  : partial remainder after the step
//   qbit     : quotient bit produced by the step
module mdu_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             din_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_nxt,
  output logic             qbit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign shifted = {rem, din_bit};
  // One extra bit so a zero divisor (remainder unbounded) still yields a
  // clean borrow flag.
  assign diff    = {1'b0, shifted} - {2'b00, divisor};
  assign qbit    = ~diff[WIDTH+1];
  assign rem_nxt = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/mdu_iterative.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
//   clk, rst       : clock, synchronous active-high reset
//   start, mdOp    : request and operation (accepted only while idle)
//   din1, din2     : rs / rt operands
//   cancel         : flush the in-flight operation, no commit
//   busy, done     : operation in progress / one-cycle commit pulse
//   hi, lo         : architectural HI and LO
//
// state | meaning
// IDLE  | waiting for a request; mthi/mtlo complete here
// ITER  | one shift-add or restoring step per clock, WIDTH steps
// FIX   | sign correction and HI/LO commit
module mdu_iterative
  import mdu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit EARLY_MUL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       mdOp,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r, b_r, acc_r;
  logic             is_div, neg_q, neg_r, dz;

  logic             op_div, op_sgn, s1, s2, mt_ok, accept;
  logic [WIDTH:0]   neg1, neg2;
  logic [WIDTH-1:0] mag1, mag2;
  logic [2*WIDTH-1:0] early_prod, prod, prod_fix;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] rem_nxt, quo_fix, rem_fix;
  logic             qbit;

  assign op_div = mdOp[1];
  assign op_sgn = ~mdOp[0];
  assign s1     = op_sgn & din1[WIDTH-1];
  assign s2     = op_sgn & din2[WIDTH-1];
  // Negation in WIDTH+1 bits: |most-negative| lands in the low WIDTH bits
  // as an unsigned magnitude.
  assign neg1   = -{s1, din1};
  assign neg2   = -{s2, din2};
  assign mag1   = s1 ? neg1[WIDTH-1:0] : din1;
  assign mag2   = s2 ? neg2[WIDTH-1:0] : din2;

  assign mt_ok  = (state == IDLE) && start && !cancel;
  assign accept = mt_ok && !mdOp[2];
  assign busy   = (state != IDLE);

  assign early_prod = {{WIDTH{1'b0}}, mag1} * {{WIDTH{1'b0}}, mag2};
  assign mul_sum    = {1'b0, acc_r} + {1'b0, (b_r[0] ? a_r : {WIDTH{1'b0}})};
  assign prod       = {acc_r, b_r};
  assign prod_fix   = neg_q ? -prod : prod;
  assign quo_fix    = dz ? {WIDTH{1'b1}} : (neg_q ? -b_r : b_r);
  // With a zero divisor the remainder register ends up holding |din1|, so
  // the usual sign fix returns din1 as issued.
  assign rem_fix    = neg_r ? -acc_r : acc_r;

  mdu_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem     (acc_r),
    .din_bit (b_r[WIDTH-1]),
    .divisor (a_r),
    .rem_nxt (rem_nxt),
    .qbit    (qbit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (EARLY_MUL && !op_div) ? FIX : ITER;
      ITER: if (cnt == CW'(WIDTH-1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (cancel) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc_r  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (mt_ok && mdOp == MD_MTHI) hi <= din1;
      if (mt_ok && mdOp == MD_MTLO) lo <= din1;
      if (accept) begin
        cnt    <= '0;
        is_div <= op_div;
        neg_q  <= s1 ^ s2;
        neg_r  <= s1;
        dz     <= (din2 == '0);
        acc_r  <= '0;
        if (op_div) begin
          a_r <= mag2;
          b_r <= mag1;
        end else begin
          a_r <= mag1;
          b_r <= mag2;
          if (EARLY_MUL) {acc_r, b_r} <= early_prod;
        end
      end else if (state == ITER) begin
        cnt <= cnt + 1'b1;
        if (is_div) begin
          acc_r <= rem_nxt;
          b_r   <= {b_r[WIDTH-2:0], qbit};
        end else begin
          // {acc_r, b_r} is the running product; multiplier bits drain
          // out of b_r's LSB as product bits shift in at its MSB.
          acc_r <= mul_sum[WIDTH:1];
          b_r   <= {mul_sum[0], b_r[WIDTH-1:1]};
        end
      end else if (state == FIX && !cancel) begin
        done <= 1'b1;
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end
  end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the EX stage and executes mult/multu/div/divu/mthi/mtlo.
- Multiply uses radix-2 shift-add; divide uses radix-2 restoring division, one bit per clock.
- Exposes busy/done so hazard logic can stall mfhi/mflo and later MDU instructions, and a cancel input for exception flush.

Parameters:
- WIDTH, 32, operand width; HI and LO are WIDTH bits each; must be ≥ 4.
- EARLY_MUL, 0, when 1 mult/multu use a single-cycle full-width product instead of iterating.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; accepted only in a cycle where busy=0.
- mdOp  input  3  operation: 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo; 11x reserved, ignored.
- din1  input  WIDTH  rs value (dividend / multiplicand / mthi-mtlo source).
- din2  input  WIDTH  rt value (divisor / multiplier).
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse; HI/LO have just been updated.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset: state=IDLE; busy=0, done=0, hi=0, lo=0; any in-flight operation is discarded. Reset overrides cancel and start.
- States: IDLE, ITER, FIX.
- Accept (IDLE, start=1, cancel=0, mult/multu/div/divu) at edge E0:
  - latch |din1|, |din2| (signed ops) or raw values (unsigned ops);
  - latch result signs: quotient/product negative iff operand signs differ; remainder sign = dividend sign;
  - clear the iteration counter;
  - go to ITER with busy=1.
- ITER: one shift-add or restore step per edge; after WIDTH steps (edge E_WIDTH) go to FIX.
- FIX, edge E_WIDTH+1:
  - apply two's-complement sign correction;
  - write hi/lo: mult → {hi,lo} = 2·WIDTH-bit product; div → lo = quotient, hi = remainder;
  - go to IDLE; busy=0; done=1 for exactly one cycle.
- Latency: busy high for WIDTH+1 cycles (33 for WIDTH=32).
- EARLY_MUL=1: mult/multu go IDLE→FIX directly, so busy lasts 1 cycle; div/divu are unchanged.
- mthi/mtlo accepted in IDLE: hi (or lo) ← din1 at the next edge. busy stays 0, done is not pulsed, the other register is untouched.
- start while busy: ignored, no side effects. Stalling the request is the caller's responsibility.
- cancel=1: next edge → IDLE, busy=0, done=0, hi/lo unchanged.
  - cancel and start in the same cycle: cancel wins, start is dropped.
  - cancel in the cycle FIX would commit: no commit.
- Divide by zero (any signedness): full latency; hi = din1 as issued, lo = all ones; no exception.
- Signed overflow (most-negative / -1): lo = most-negative value, hi = 0; no exception.
- Division truncates toward zero.
- Absolute value of the most-negative operand is computed in WIDTH+1 bits, so there is no intermediate overflow.
- hi/lo hold their previous values throughout an operation; no partial results are visible.

Decomposition:
- Package mdu_pkg holds:
  - mdOp encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO);
  - the state enum;
  - the hazard helper constant MDU_LAT = WIDTH+1.
- One natural sub-module: mdu_div_step, a combinational single restoring step (partial remainder, divisor → next remainder, quotient bit), parameterised by WIDTH.
- The multiply step stays inline.

Test Plan:
- mult, din1=0xFFFFFFFF, din2=2 → done 33 cycles after accept; hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu, same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div -7/2 (0xFFFFFFF9, 2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 → lo=3, hi=1. div 7/-2 → lo=0xFFFFFFFD, hi=1.
- divu 0x12345678/0 and div 0x80000000/0 → hi=din1, lo=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → lo=0x80000000, hi=0.
- Start a divu, then hold start with new operands on cycles 1–5 → ignored, result matches the first operands. Cancel at iteration 10 → busy=0 next cycle, no done, hi/lo keep prior values.
- mthi 0xDEADBEEF then mtlo 0x0BADF00D → hi/lo updated in 1 cycle each, busy never set. rst mid-divide → busy=0, hi=lo=0, no done.
- EARLY_MUL=1: multu 0x10000×0x10000 → busy 1 cycle, hi=1, lo=0. WIDTH=8: div 0x80/0xFF → lo=0x80, hi=0, busy 9 cycles.
